// File: rtl/cpu_param.sv
// cpu_param: parametrised accumulator CPU with FETCH/OPERAND instruction FSM.
// Ports:
//   clk       - clock, all state updates on rising edge
//   reset     - asynchronous active-low reset
//   in        - instruction or operand word (DATA_W bits)
//   out       - registered output data, holds between output instructions
//   out_valid - one-cycle strobe after out is updated
//   carry     - carry/borrow flag (0 unless CPU_FLAGS_EN is defined)
//   zero      - result-zero flag (0 unless CPU_FLAGS_EN is defined)
// Optional feature macro: CPU_FLAGS_EN enables the carry/zero flag registers.
module cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              carry,
  output logic              zero
);
  typedef enum logic {FETCH, OPERAND} state_t;
  state_t state;
  logic [DATA_W-1:0] a, b, c, res;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [3:0] op, pend_op;
  logic [ADDR_W-1:0] addr, pend_addr;
  assign op = in[DATA_W-1 -: 4];
  assign addr = in[ADDR_W-1:0];
  always_comb begin
    res = '0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a + DATA_W'(1);
      4'd3: res = a - DATA_W'(1);
      4'd4: res = a + b + DATA_W'(1);
      4'd5: res = -a;
      default: res = '0;
    endcase
  end
  // Memory has no reset; contents survive reset pulses.
  always_ff @(posedge clk) begin
    if (state == FETCH && op == 4'd9) mem[addr] <= c;
    else if (state == OPERAND && pend_op == 4'd8) mem[pend_addr] <= in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      a <= '0;
      b <= '0;
      c <= '0;
      out <= '0;
      out_valid <= 1'b0;
      pend_op <= '0;
      pend_addr <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == OPERAND) begin
        // Second word of a two-word instruction: never decoded as an opcode.
        state <= FETCH;
        case (pend_op)
          4'd6: a <= in;
          4'd7: b <= in;
          4'd10: c <= mem[pend_addr];
          4'd12: begin
            out <= mem[pend_addr];
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (op)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: c <= res;
          4'd11: begin
            out <= c;
            out_valid <= 1'b1;
          end
          4'd13: a <= c;
          4'd14: b <= c;
          4'd6, 4'd7, 4'd8, 4'd10, 4'd12: begin
            state <= OPERAND;
            pend_op <= op;
            pend_addr <= addr;
          end
          default: ;
        endcase
      end
    end
  end
`ifdef CPU_FLAGS_EN
  logic cy;
  // Carry derived from the wrapped result: an add wrapped iff the sum fell below A.
  always_comb begin
    cy = 1'b0;
    case (op)
      4'd0: cy = res < a;
      4'd1: cy = a < b;
      4'd2: cy = a == '1;
      4'd3: cy = a == '0;
      4'd4: cy = res <= a;
      4'd5: cy = a != '0;
      default: cy = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
      zero <= 1'b0;
    end else if (state == FETCH && op <= 4'd5) begin
      carry <= cy;
      zero <= res == '0;
    end
  end
`else
  assign carry = 1'b0;
  assign zero = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: randomized self-checking bench for cpu_param (8-bit and 16-bit instances).
module tb_cpu_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in0 = '1, out0;
  logic [15:0] in1 = '1, out1;
  logic v0, v1, c0, c1, z0, z1;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
`ifdef CPU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  cpu_param #(.DATA_W(8), .ADDR_W(4)) dut0 (
    .clk(clk), .reset(reset), .in(in0), .out(out0),
    .out_valid(v0), .carry(c0), .zero(z0)
  );
  cpu_param #(.DATA_W(16), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .out(out1),
    .out_valid(v1), .carry(c1), .zero(z1)
  );

  always #5 clk = ~clk;

  int unsigned ma[2], mb[2], mc[2], mo[2], mv[2], mcy[2], mz[2], pop[2], pad[2];
  bit pend[2];
  int unsigned mem[2][256];
  int w[2] = '{8, 16};
  int aw[2] = '{4, 8};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ma[i] = 0; mb[i] = 0; mc[i] = 0; mo[i] = 0; mv[i] = 0;
      mcy[i] = 0; mz[i] = 0; pend[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i, int unsigned x);
    int unsigned mask, op, ad, r;
    mask = (32'd1 << w[i]) - 1;
    mv[i] = 0;
    if (pend[i]) begin
      pend[i] = 1'b0;
      case (pop[i])
        6: ma[i] = x;
        7: mb[i] = x;
        8: mem[i][pad[i]] = x;
        10: mc[i] = mem[i][pad[i]];
        12: begin mo[i] = mem[i][pad[i]]; mv[i] = 1; end
        default: ;
      endcase
    end else begin
      op = x >> (w[i] - 4);
      ad = x & ((32'd1 << aw[i]) - 1);
      if (op <= 5) begin
        r = 0;
        case (op)
          0: begin r = ma[i] + mb[i]; mcy[i] = (r > mask); end
          1: begin r = ma[i] - mb[i]; mcy[i] = (ma[i] < mb[i]); end
          2: begin r = ma[i] + 1; mcy[i] = (r > mask); end
          3: begin r = ma[i] - 1; mcy[i] = (ma[i] == 0); end
          4: begin r = ma[i] + mb[i] + 1; mcy[i] = (r > mask); end
          default: begin r = 0 - ma[i]; mcy[i] = (ma[i] != 0); end
        endcase
        r = r & mask;
        mc[i] = r;
        mz[i] = (r == 0);
      end else if (op == 6 || op == 7 || op == 8 || op == 10 || op == 12) begin
        pend[i] = 1'b1; pop[i] = op; pad[i] = ad;
      end else begin
        case (op)
          9: mem[i][ad] = mc[i];
          11: begin mo[i] = mc[i]; mv[i] = 1; end
          13: ma[i] = mc[i];
          14: mb[i] = mc[i];
          default: ;
        endcase
      end
    end
  endtask

  task automatic cmp(string name, int i, int unsigned act, int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out", 0, out0, mo[0]);
      cmp("out_valid", 0, v0, mv[0]);
      cmp("carry", 0, c0, FLAGS ? mcy[0] : 0);
      cmp("zero", 0, z0, FLAGS ? mz[0] : 0);
      cmp("out", 1, out1, mo[1]);
      cmp("out_valid", 1, v1, mv[1]);
      cmp("carry", 1, c1, FLAGS ? mcy[1] : 0);
      cmp("zero", 1, z1, FLAGS ? mz[1] : 0);
    end
  end

  task automatic word(int unsigned x0, int unsigned x1);
    in0 = x0[7:0];
    in1 = x1[15:0];
    @(posedge clk);
    model_step(0, in0);
    model_step(1, in1);
    #1;
  endtask

  task automatic send(int unsigned op, int unsigned ad);
    word((op << 4) | ad, (op << 12) | ad);
  endtask

  task automatic data(int unsigned v);
    word(v & 'hFF, v & 'hFFFF);
  endtask

  task automatic pulse_reset();
    in0 = '1;
    in1 = '1;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pin(string name, int unsigned act, int unsigned exp);
    cmp(name, 0, act, exp);
  endtask

  initial begin
    int unsigned op, ad;
    model_reset();
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    pin("rst_out", out0, 0);
    pin("rst_valid", v0, 0);
    // Basic add and output
    send(6, 0); data('h0F);
    send(7, 0); data('h01);
    send(0, 0);
    send(11, 0);
    pin("s1_out", out0, 'h10);
    pin("s1_valid", v0, 1);
    pin("s1_out16", out1, 'h10);
    pin("s1_model_out", mo[0], 'h10);
    pin("s1_carry", c0, 0);
    pin("s1_zero", z0, 0);
    send(15, 0);
    pin("s1_valid_drop", v0, 0);
    // Overflow, store, read back
    send(6, 0); data('hFF);
    send(7, 0); data('hFF);
    send(0, 0);
    pin("s2_add_carry", c0, FLAGS);
    pin("s2_add_model", mc[0], 'hFE);
    send(1, 0);
    pin("s2_sub_zero", z0, FLAGS);
    pin("s2_sub_carry", c0, 0);
    pin("s2_sub_model", mc[0], 0);
    send(9, 15);
    send(12, 15); data('hFF);
    pin("s2_rd_out", out0, 0);
    pin("s2_rd_valid", v0, 1);
    // Increment/decrement edges
    send(2, 0);
    pin("s3_inc_model", mc[0], 0);
    pin("s3_inc_carry", c0, FLAGS);
    pin("s3_inc_zero", z0, FLAGS);
    send(3, 0);
    pin("s3_dec_model", mc[0], 'hFE);
    send(4, 0);
    pin("s3_adc_model", mc[0], 'hFF);
    pin("s3_adc_carry", c0, FLAGS);
    // Negate and register moves
    send(6, 0); data('h01);
    send(5, 0);
    pin("s4_neg_model", mc[0], 'hFF);
    pin("s4_neg_carry", c0, FLAGS);
    send(13, 0);
    send(14, 0);
    send(0, 0);
    send(11, 0);
    pin("s4_out", out0, 'hFE);
    // Memory path
    send(8, 3); data('h5A);
    send(10, 3); data('h00);
    send(11, 0);
    pin("s5_out", out0, 'h5A);
    send(12, 3);
    pin("s5_valid_gap", v0, 0);
    data('h00);
    pin("s5_out2", out0, 'h5A);
    pin("s5_valid2", v0, 1);
    // Reset mid-instruction
    send(6, 0);
    pulse_reset();
    pin("s6_out", out0, 0);
    pin("s6_valid", v0, 0);
    send(2, 15);
    send(11, 0);
    pin("s6_out", out0, 1);
    pin("s6_out16", out1, 1);
    // Randomized phase: memory fully written first so every read is defined
    for (int k = 0; k < 16; k++) begin
      send(8, k);
      data($urandom);
    end
    repeat (1500) begin
      op = $urandom_range(0, 15);
      ad = $urandom_range(0, 15);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      send(op, ad);
      if (op == 6 || op == 7 || op == 8 || op == 10 || op == 12) data($urandom);
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
